// File: rtl/wta_disparity_select.sv
`default_nettype none
// ============================================================================
// Module   : wta_disparity_select
// Brief    : Winner-takes-all disparity selector. Consumes one matching cost
//            per cycle for disparities 0..MAX_DISP-1 and reports the index
//            and cost of the minimum. Lower disparity wins on ties.
//            Optional uniqueness test against the second-best cost is built
//            when the macro WTA_UNIQUENESS_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module wta_disparity_select #(
    parameter  int MAX_DISP    = 16,
    parameter  int COST_WIDTH  = 4,
    parameter  int UNIQ_MARGIN = 1,
    localparam int DISP_WIDTH  = $clog2(MAX_DISP)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COST_WIDTH-1:0] cost_in,
    input  logic                  cost_valid,
    input  logic                  cost_first,
    output logic [DISP_WIDTH-1:0] disp_out,
    output logic [COST_WIDTH-1:0] min_cost_out,
    output logic                  disp_unique,
    output logic                  disp_valid,
    output logic                  seq_err
);

    localparam int                   CNT_WIDTH  = DISP_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] C_CNT_LAST = CNT_WIDTH'(MAX_DISP - 1);
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = CNT_WIDTH'(1);

    // IDLE: no partial pixel held; ACCUM: d_cnt costs of a pixel accepted
    localparam logic [0:0] C_ST_IDLE  = 1'b0;
    localparam logic [0:0] C_ST_ACCUM = 1'b1;

    // Elaboration-time parameter sanity
    if (MAX_DISP < 2 || MAX_DISP > 256) begin : g_bad_max_disp
        $error("wta_disparity_select: MAX_DISP out of range 2..256");
    end
    if (UNIQ_MARGIN < 0) begin : g_bad_margin
        $error("wta_disparity_select: UNIQ_MARGIN must be non-negative");
    end

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [CNT_WIDTH-1:0]  r_d_cnt;
    logic [CNT_WIDTH-1:0]  w_d_cnt_nxt;
    logic [COST_WIDTH-1:0] r_best_cost;
    logic [COST_WIDTH-1:0] w_best_cost_nxt;
    logic [DISP_WIDTH-1:0] r_best_idx;
    logic [DISP_WIDTH-1:0] w_best_idx_nxt;
    logic                  w_start;
    logic                  w_better;
    logic                  w_resync;
    logic                  w_last;
    logic                  w_unique;

    // A cost opens a new pixel when nothing is pending or upstream flags it
    assign w_start  = cost_valid && ((r_state == C_ST_IDLE) || cost_first);
    // Strict compare keeps the lower disparity on ties
    assign w_better = cost_in < r_best_cost;

    // Next-state, counter and running-minimum update
    always_comb begin
        w_state_nxt     = r_state;
        w_d_cnt_nxt     = r_d_cnt;
        w_best_cost_nxt = r_best_cost;
        w_best_idx_nxt  = r_best_idx;
        w_resync        = 1'b0;
        w_last          = 1'b0;
        if (w_start) begin
            // A flagged first cost while a pixel is pending drops that pixel
            w_resync        = (r_state == C_ST_ACCUM);
            w_state_nxt     = C_ST_ACCUM;
            w_d_cnt_nxt     = C_CNT_ONE;
            w_best_cost_nxt = cost_in;
            w_best_idx_nxt  = '0;
        end else if (cost_valid) begin
            if (w_better) begin
                w_best_cost_nxt = cost_in;
                w_best_idx_nxt  = r_d_cnt[DISP_WIDTH-1:0];
            end
            if (r_d_cnt == C_CNT_LAST) begin
                w_last      = 1'b1;
                w_state_nxt = C_ST_IDLE;
                w_d_cnt_nxt = '0;
            end else begin
                w_d_cnt_nxt = r_d_cnt + C_CNT_ONE;
            end
        end
    end

    // State, counter and running-minimum registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= C_ST_IDLE;
            r_d_cnt     <= '0;
            r_best_cost <= '0;
            r_best_idx  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_d_cnt     <= w_d_cnt_nxt;
            r_best_cost <= w_best_cost_nxt;
            r_best_idx  <= w_best_idx_nxt;
        end
    end

`ifdef WTA_UNIQUENESS_CHECK_EN
    localparam logic [COST_WIDTH:0] C_MARGIN = (COST_WIDTH + 1)'(UNIQ_MARGIN);

    logic [COST_WIDTH-1:0] r_second_cost;
    logic [COST_WIDTH-1:0] w_second_nxt;

    // Second-best tracks the minimum over every disparity except the winner
    always_comb begin
        w_second_nxt = r_second_cost;
        if (w_start) begin
            w_second_nxt = '1;
        end else if (cost_valid) begin
            if (w_better) begin
                w_second_nxt = r_best_cost;
            end else if (cost_in < r_second_cost) begin
                w_second_nxt = cost_in;
            end
        end
    end

    // Second-best cost register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_second_cost <= '0;
        end else begin
            r_second_cost <= w_second_nxt;
        end
    end

    // Second-best is never below best, so the unsigned gap cannot wrap
    assign w_unique = (({1'b0, w_second_nxt} - {1'b0, w_best_cost_nxt}) >= C_MARGIN);
`else
    assign w_unique = 1'b1;
`endif

    // Result registers hold until the next completed pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_out     <= '0;
            min_cost_out <= '0;
            disp_unique  <= 1'b0;
            disp_valid   <= 1'b0;
            seq_err      <= 1'b0;
        end else begin
            disp_valid <= w_last;
            seq_err    <= w_resync;
            if (w_last) begin
                disp_out     <= w_best_idx_nxt;
                min_cost_out <= w_best_cost_nxt;
                disp_unique  <= w_unique;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wta_disparity_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_wta_disparity_select
// Brief    : Self-checking bench for wta_disparity_select. Directed pixels
//            plus randomized streams with bubbles, resyncs and resets,
//            compared every cycle against a pixel-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wta_disparity_select;

    localparam int MAX_DISP    = 16;
    localparam int COST_WIDTH  = 4;
    localparam int UNIQ_MARGIN = 1;
    localparam int DISP_WIDTH  = $clog2(MAX_DISP);
    localparam int C_COST_MAX  = (1 << COST_WIDTH) - 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [COST_WIDTH-1:0] cost_in;
    logic                  cost_valid;
    logic                  cost_first;
    logic [DISP_WIDTH-1:0] disp_out;
    logic [COST_WIDTH-1:0] min_cost_out;
    logic                  disp_unique;
    logic                  disp_valid;
    logic                  seq_err;

    wta_disparity_select #(
        .MAX_DISP    (MAX_DISP),
        .COST_WIDTH  (COST_WIDTH),
        .UNIQ_MARGIN (UNIQ_MARGIN)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .cost_in      (cost_in),
        .cost_valid   (cost_valid),
        .cost_first   (cost_first),
        .disp_out     (disp_out),
        .min_cost_out (min_cost_out),
        .disp_unique  (disp_unique),
        .disp_valid   (disp_valid),
        .seq_err      (seq_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: costs of the pixel in progress, and the last result
    int pix[$];
    int exp_disp;
    int exp_cost;
    int exp_uniq;
    int exp_valid;
    int exp_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Winner = lowest-index minimum; second = minimum of all other costs
    task automatic resolve_pixel();
        int best;
        int idx;
        int second;
        best   = pix[0];
        idx    = 0;
        second = C_COST_MAX;
        for (int i = 1; i < pix.size(); i++) begin
            if (pix[i] < best) begin
                best = pix[i];
                idx  = i;
            end
        end
        for (int i = 0; i < pix.size(); i++) begin
            if (i != idx && pix[i] < second) second = pix[i];
        end
        exp_disp = idx;
        exp_cost = best;
`ifdef WTA_UNIQUENESS_CHECK_EN
        exp_uniq = ((second - best) >= UNIQ_MARGIN) ? 1 : 0;
`else
        exp_uniq = 1;
`endif
    endtask

    // Drive one cycle, advance the model, then compare all outputs
    task automatic step(input bit r, input bit v, input bit f, input int c);
        rst        = r;
        cost_valid = v;
        cost_first = f;
        cost_in    = c[COST_WIDTH-1:0];
        @(posedge clk);
        exp_valid = 0;
        exp_err   = 0;
        if (r) begin
            pix.delete();
            exp_disp = 0;
            exp_cost = 0;
            exp_uniq = 0;
        end else if (v) begin
            if (pix.size() != 0 && f) begin
                exp_err = 1;
                pix.delete();
            end
            pix.push_back(c & C_COST_MAX);
            if (pix.size() == MAX_DISP) begin
                resolve_pixel();
                exp_valid = 1;
                pix.delete();
            end
        end
        #1;
        check("disp_valid", 32'(disp_valid), 32'(exp_valid));
        check("seq_err", 32'(seq_err), 32'(exp_err));
        check("disp_out", 32'(disp_out), 32'(exp_disp));
        check("min_cost_out", 32'(min_cost_out), 32'(exp_cost));
        check("disp_unique", 32'(disp_unique), 32'(exp_uniq));
    endtask

    task automatic full_pixel_rand(input int maxc);
        for (int d = 0; d < MAX_DISP; d++) step(0, 1, d == 0, $urandom_range(maxc, 0));
    endtask

    initial begin
        rst        = 1'b1;
        cost_valid = 1'b0;
        cost_first = 1'b0;
        cost_in    = '0;
        exp_disp = 0; exp_cost = 0; exp_uniq = 0; exp_valid = 0; exp_err = 0;
        repeat (3) step(1, 0, 0, 0);

        // Descending 8..0 up to d=8, then 5: winner d=8, cost 0
        for (int d = 0; d < MAX_DISP; d++) step(0, 1, d == 0, (d <= 8) ? (8 - d) : 5);
        step(0, 0, 0, 0);
        check("t1_disp", 32'(disp_out), 32'd8);
        check("t1_cost", 32'(min_cost_out), 32'd0);

        // All equal: lowest disparity wins the tie
        for (int d = 0; d < MAX_DISP; d++) step(0, 1, d == 0, 3);
        check("t2_disp", 32'(disp_out), 32'd0);
        check("t2_cost", 32'(min_cost_out), 32'd3);
`ifdef WTA_UNIQUENESS_CHECK_EN
        check("t2_uniq", 32'(disp_unique), 32'd0);
`endif

        // Best 1 at d=4, second 2 elsewhere, then an exact tie for best
        for (int d = 0; d < MAX_DISP; d++) step(0, 1, d == 0, (d == 4) ? 1 : (d == 9) ? 2 : 6);
        for (int d = 0; d < MAX_DISP; d++) step(0, 1, d == 0, (d == 4) ? 1 : (d == 9) ? 1 : 6);
        check("t3_disp", 32'(disp_out), 32'd4);

        // Resync after 5 costs, with the pixel then completed from the new start
        for (int d = 0; d < 5; d++) step(0, 1, d == 0, $urandom_range(C_COST_MAX, 0));
        step(0, 1, 1, 2);
        for (int d = 0; d < MAX_DISP - 1; d++) step(0, 1, 0, $urandom_range(C_COST_MAX, 3));
        check("t4_cost", 32'(min_cost_out), 32'd2);

        // Resync on the last expected slot
        for (int d = 0; d < MAX_DISP - 1; d++) step(0, 1, d == 0, $urandom_range(C_COST_MAX, 0));
        step(0, 1, 1, 7);
        full_pixel_rand(C_COST_MAX);

        // Reset mid-pixel, then a full pixel
        for (int d = 0; d < 10; d++) step(0, 1, d == 0, $urandom_range(C_COST_MAX, 0));
        repeat (2) step(1, 1, 0, 4);
        full_pixel_rand(C_COST_MAX);

        // Randomized stream: bubbles, back-to-back pixels, rare resyncs/unflagged starts
        for (int n = 0; n < 1500; n++) begin
            int  r;
            bit  v;
            bit  f;
            r = $urandom_range(99, 0);
            v = ($urandom_range(3, 0) != 0);
            if (pix.size() == 0) f = (r >= 10);
            else                 f = (r < 3);
            step(r == 99, v, f, $urandom_range((n % 3 == 0) ? 3 : C_COST_MAX, 0));
        end
        step(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wta_disparity_select.md
# wta_disparity_select

Winner-takes-all disparity selector sitting directly downstream of the Hamming-distance stage. It consumes one matching cost per cycle for disparities 0..MAX_DISP-1 of the current pixel and emits the disparity with the minimum cost. It optionally emits a uniqueness flag derived from the second-best cost. Its output feeds the depth-map writer.

## Interface
- MAX_DISP, 16, number of candidate disparities per pixel, 2..256
- COST_WIDTH, 4, cost bit width; 4 matches the 8-bit census stage
- DISP_WIDTH, $clog2(MAX_DISP), disparity index width (localparam)
- UNIQ_MARGIN, 1, minimum required gap between the best and second-best cost; used only with the uniqueness feature
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cost_in  in  COST_WIDTH  Hamming cost for the current disparity
- cost_valid  in  1  cost_in is valid this cycle
- cost_first  in  1  qualifies cost_valid; this cost is disparity 0 of a new pixel
- disp_out  out  DISP_WIDTH  winning disparity
- min_cost_out  out  COST_WIDTH  cost of the winner
- disp_unique  out  1  winner passes the uniqueness test
- disp_valid  out  1  single-cycle pulse; outputs valid
- seq_err  out  1  single-cycle pulse; a partial pixel was discarded

## Operation
- Internal disparity counter d_cnt (DISP_WIDTH+1 bits) counts accepted costs for the current pixel.
- Accept condition: cost_valid=1. Cycles with cost_valid=0 are bubbles and change no state.
- First cost of a pixel: accepted when d_cnt==0, or when cost_first=1. The running minimum loads cost_in, the best index loads 0, and d_cnt becomes 1.
- Subsequent costs: if cost_in < best_cost (strict), best_cost and best_idx are replaced. Ties keep the lower disparity.
- After the MAX_DISP-th accepted cost, the result registers load and d_cnt returns to 0. No idle cycle is needed; disparity 0 of the next pixel may arrive on the next cycle.
- Resync: cost_first=1 with cost_valid=1 while d_cnt!=0 discards the partial pixel. It pulses seq_err and starts the new pixel with this cost. No disp_valid is emitted for the discarded pixel.
- cost_first=1 on the last-expected slot (d_cnt==MAX_DISP-1) is also a resync. The partial pixel is discarded.
- cost_first=1 with d_cnt==0 is normal and raises no error.
- A cost with cost_first=0 while d_cnt==0 is treated as disparity 0. No error is raised; the upstream stage is free-running.
- Two-state view: IDLE (d_cnt==0) and ACCUM (d_cnt!=0). IDLE goes to ACCUM on an accepted cost. ACCUM goes to IDLE on the final cost. ACCUM stays in ACCUM on a resync.

## Timing
- Latency: disp_valid is asserted in the cycle after the clock edge that accepts the MAX_DISP-th cost. That is 1 cycle after the last cost.
- disp_out, min_cost_out and disp_unique hold their values until the next disp_valid.
- seq_err is asserted in the cycle after the offending cost.
- Reset: d_cnt=0, disp_out=0, min_cost_out=0, disp_unique=0, disp_valid=0, seq_err=0, and all internal min/second-min registers cleared.
- Reset asserted mid-pixel drops the partial pixel silently; no seq_err is raised.
- Throughput: one cost per cycle sustained, i.e. one pixel per MAX_DISP cycles. There is no backpressure.

## Configuration
- WTA_UNIQUENESS_CHECK_EN defined:
  - A second-best cost register tracks the minimum over all other disparities. It initialises to all-ones on the first cost. When a new best is found, the old best shifts into second-best.
  - disp_unique = (second_cost - best_cost) >= UNIQ_MARGIN. Exact ties therefore fail whenever UNIQ_MARGIN>0.
- Undefined:
  - No second-best logic is built.
  - disp_unique=1 with every disp_valid, and 0 after reset until the first result.

## Test plan
- MAX_DISP=16, costs 8,7,...,0 at d=8 then 5 for the rest, no bubbles -> disp_valid 1 cycle after the 16th cost, disp_out=8, min_cost_out=0.
- All 16 costs =3 -> disp_out=0 (lowest disparity wins the tie), min_cost_out=3; with WTA_UNIQUENESS_CHECK_EN and UNIQ_MARGIN=1, disp_unique=0.
- With WTA_UNIQUENESS_CHECK_EN and UNIQ_MARGIN=2: best 1 at d=4, second 3, all others 6 -> disp_unique=1; change the second-best to 2 -> disp_unique=0.
- Pixel with random bubbles (cost_valid low for 1-3 cycles) followed back-to-back by a second pixel -> two disp_valid pulses, results match a reference model, no seq_err.
- After 5 costs, assert cost_first with cost 2, then 15 more costs -> seq_err pulse 1 cycle later; a single disp_valid whose result covers only the new pixel.
- rst asserted after 10 costs, then a full pixel -> all outputs 0 during reset; no seq_err; one correct disp_valid for the new pixel.
